keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Scans the 4x4 matrix keypad and debounces the keys. Converts key presses into the
//  player row position (playerPos) and the fire request (fire) for the Raiden top level.
//  Sits directly upstream of the game top, which uses playerPos and fire for ship
//  drawing and bullet spawning.
// PARAMETERS
//  SCAN_DIV        1000  clk cycles per row slot, minus 1 (slot length = SCAN_DIV+1)
//  DEBOUNCE_SCANS  4     consecutive identical full scans before a key change is accepted
//  POS_MIN         1     lowest legal playerPos (ship spans pos-1..pos+1)
//  POS_MAX         6     highest legal playerPos
//  POS_RESET       3     playerPos after reset
//  KEY_UP          4'h1  key code that decrements playerPos (code = row*4 + col)
//  KEY_DOWN        4'h9  key code that increments playerPos
//  KEY_FIRE        4'h5  key code that drives fire
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous reset, active-low
//  keypadRow  out  4  row drive, one-hot active-low (row r driven = bit r is 0)
//  keypadCol  in   4  column sense, active-low (0 = key at driven row/col pressed)
//  playerPos  out  3  ship centre row, held in POS_MIN..POS_MAX
//  fire       out  1  1 while the debounced KEY_FIRE is held
// BEHAVIOUR
//  Reset (rst=0, async): keypadRow=4'b1110, playerPos=POS_RESET, fire=0. Slot counter,
//   row index, raw/prev/debounced 16-bit key vectors and stable counter all cleared.
//  Scan FSM: SCAN -> EVAL -> SCAN.
//   SCAN: drive row r (r=0..3); count 0..SCAN_DIV. In the cycle the count equals
//    SCAN_DIV, latch ~keypadCol into raw[r*4 +: 4]; then advance r (wrap 3->0) and
//    update keypadRow in the next cycle. After the row-3 sample, go to EVAL.
//   EVAL (exactly 1 cycle; keypadRow holds row 0):
//    raw==prev: stable = min(stable+1, DEBOUNCE_SCANS); else stable=0, prev=raw.
//    When stable reaches DEBOUNCE_SCANS and prev!=deb: deb<=prev,
//     rise = prev & ~deb (one-cycle event vector).
//  Outputs: registered, updated in the cycle after EVAL.
//   fire = deb[KEY_FIRE] (level; the game samples it on its slow tick).
//   rise[KEY_UP] & !rise[KEY_DOWN]: playerPos-1, saturating at POS_MIN.
//   rise[KEY_DOWN] & !rise[KEY_UP]: playerPos+1, saturating at POS_MAX.
//   Both rising in the same EVAL: no move. Holding a key gives exactly one step (no
//   auto-repeat). A new step needs release, debounce, and a new press.
//   Other keys are scanned and debounced but have no effect.
//  Timing: full scan = 4*(SCAN_DIV+1)+1 cycles. A clean press appears on the outputs
//   after at most DEBOUNCE_SCANS+2 scans.
//  Bounce: any raw change resets stable to 0, so glitches shorter than DEBOUNCE_SCANS
//   scans are never accepted.
//  Mid-operation reset: all state returns to reset values at once. The scan restarts
//   at row 0, and deb=0, so a key still held after reset counts as a new press.
//  Width rules: playerPos is 3-bit unsigned, compared against POS_MIN/POS_MAX before
//   any +/-1, so it never wraps. The slot counter is wide enough for SCAN_DIV
//   ($clog2(SCAN_DIV+1)).
// STRUCTURE
//  Shared package raiden_pkg: KEY_UP/KEY_DOWN/KEY_FIRE codes, POS_MIN/POS_MAX/POS_RESET,
//   scan FSM state enum (SCAN, EVAL).
//  One sub-module: keypad_debounce (16-bit raw vector in, scan-done strobe in,
//   deb + rise vectors out; holds prev/stable). The top keeps row drive, slot counter
//   and position logic.
// TESTING (SCAN_DIV=4, DEBOUNCE_SCANS=4; keypad model drives keypadCol from keypadRow)
//  1 Reset, no keys -> keypadRow cycles 1110,1101,1011,0111 every 5 clk; playerPos=3,
//    fire=0 throughout.
//  2 Hold KEY_UP for 10 scans -> playerPos 3->2 exactly once, within 6 scans of press;
//    stays 2 while held.
//  3 Press KEY_UP 5 times (release >=6 scans between) -> playerPos 3,2,1,1,1,1 (sat POS_MIN);
//    same with KEY_DOWN from 6 -> stays 6.
//  4 KEY_UP toggling every scan for 3 scans, then released -> playerPos unchanged;
//    stable never reaches 4.
//  5 Hold KEY_FIRE with KEY_UP and KEY_DOWN pressed in the same scan -> fire=1 after
//    debounce, playerPos unchanged; fire=0 within 6 scans of release.
//  6 Assert rst mid-row-2 while KEY_DOWN held, playerPos=5 -> outputs reset at once
//    (pos=3, keypadRow=1110); after release of rst, playerPos becomes 4 (new press).

Source files
------------

// File: rtl/raiden_pkg.sv
// Shared constants and types for the Raiden keypad front end.
package raiden_pkg;

    localparam logic [3:0] KEY_UP    = 4'h1;
    localparam logic [3:0] KEY_DOWN  = 4'h9;
    localparam logic [3:0] KEY_FIRE  = 4'h5;

    localparam logic [2:0] POS_MIN   = 3'd1;
    localparam logic [2:0] POS_MAX   = 3'd6;
    localparam logic [2:0] POS_RESET = 3'd3;

    typedef enum logic {SCAN, EVAL} scan_state_t;

endpackage

// File: rtl/keypad_debounce.sv
// Full-scan debouncer: a key vector is accepted only after DEBOUNCE_SCANS
// consecutive identical scans; rise flags newly accepted presses for one cycle.
module keypad_debounce
    import raiden_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] raw,
    input  logic        scan_done,
    output logic [15:0] deb,
    output logic [15:0] rise
);

    localparam int unsigned SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

    logic [15:0]   prev;
    logic [SW-1:0] stable;
    logic [SW-1:0] stable_next;

    always_comb begin
        stable_next = stable;
        if (raw == prev) begin
            if (stable != STABLE_MAX) stable_next = stable + SW'(1);
        end else begin
            stable_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev   <= '0;
            stable <= '0;
            deb    <= '0;
            rise   <= '0;
        end else begin
            rise <= '0;
            if (scan_done) begin
                stable <= stable_next;
                if (raw != prev) prev <= raw;
                // Acceptance uses the post-increment count so the Nth identical scan commits.
                if (raw == prev && stable_next == STABLE_MAX && prev != deb) begin
                    deb  <= prev;
                    rise <= prev & ~deb;
                end
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with debounce; produces ship position and fire level.
module keypad_scanner
    import raiden_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] keypadRow,
    input  logic [3:0] keypadCol,
    output logic [2:0] playerPos,
    output logic       fire
);

    localparam int unsigned CW = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV);

    scan_state_t   state;
    logic [CW-1:0] cnt;
    logic [1:0]    row;
    logic [15:0]   raw;
    logic [15:0]   deb;
    logic [15:0]   rise;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SCAN;
            cnt       <= '0;
            row       <= '0;
            raw       <= '0;
            keypadRow <= 4'b1110;
        end else begin
            case (state)
                SCAN: begin
                    if (cnt == CNT_MAX) begin
                        raw[{row, 2'b00} +: 4] <= ~keypadCol;
                        cnt       <= '0;
                        row       <= row + 2'd1;
                        keypadRow <= ~(4'b0001 << (row + 2'd1));
                        if (row == 2'd3) state <= EVAL;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                EVAL:    state <= SCAN;
                default: state <= SCAN;
            endcase
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_deb (
        .clk      (clk),
        .rst      (rst),
        .raw      (raw),
        .scan_done(state == EVAL),
        .deb      (deb),
        .rise     (rise)
    );

    // Bounds are checked before stepping, so the 3-bit position never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            playerPos <= POS_RESET;
            fire      <= 1'b0;
        end else begin
            fire <= deb[KEY_FIRE];
            if (rise[KEY_UP] && !rise[KEY_DOWN] && playerPos > POS_MIN)
                playerPos <= playerPos - 3'd1;
            else if (rise[KEY_DOWN] && !rise[KEY_UP] && playerPos < POS_MAX)
                playerPos <= playerPos + 3'd1;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural keypad matrix model.
module tb_keypad_scanner;

    localparam int SCAN_CYC = 21;
    localparam logic [15:0] K_UP   = 16'h0002;
    localparam logic [15:0] K_DOWN = 16'h0200;
    localparam logic [15:0] K_FIRE = 16'h0020;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  keypadRow;
    logic [3:0]  keypadCol;
    logic [2:0]  playerPos;
    logic        fire;
    logic [15:0] keys = '0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] keys;
        logic [2:0]  exp_pos;
        logic        exp_fire;
    } vec_t;

    typedef struct {
        logic [2:0] pos;
        logic       fire;
    } exp_t;

    vec_t vecs[15];
    exp_t sb[$];

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV(4),
        .DEBOUNCE_SCANS(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .keypadRow(keypadRow),
        .keypadCol(keypadCol),
        .playerPos(playerPos),
        .fire     (fire)
    );

    always_comb begin
        keypadCol = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !keypadRow[r]) keypadCol[c] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_scans(input int n);
        repeat (n * SCAN_CYC) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [3:0] exp_row(input int k);
        int m;
        int r;
        if (k < 20) r = k / 5;
        else begin
            m = (k - 20) % SCAN_CYC;
            r = (m < 6) ? 0 : 1 + (m - 6) / 5;
        end
        return ~(4'b0001 << r);
    endfunction

    initial begin
        int changes;
        int first_chg;
        logic [2:0] last;
        exp_t e;
        bit found;

        // Press/release table: each key held 7 scans, then released 7 scans.
        vecs[0]  = '{K_UP,   3'd2, 1'b0};
        vecs[1]  = '{K_UP,   3'd1, 1'b0};
        vecs[2]  = '{K_UP,   3'd1, 1'b0};
        vecs[3]  = '{K_UP,   3'd1, 1'b0};
        vecs[4]  = '{K_UP,   3'd1, 1'b0};
        vecs[5]  = '{K_DOWN, 3'd2, 1'b0};
        vecs[6]  = '{K_DOWN, 3'd3, 1'b0};
        vecs[7]  = '{K_DOWN, 3'd4, 1'b0};
        vecs[8]  = '{K_DOWN, 3'd5, 1'b0};
        vecs[9]  = '{K_DOWN, 3'd6, 1'b0};
        vecs[10] = '{K_DOWN, 3'd6, 1'b0};
        vecs[11] = '{K_FIRE, 3'd6, 1'b1};
        vecs[12] = '{K_UP | K_DOWN | K_FIRE, 3'd6, 1'b1};
        vecs[13] = '{K_UP | K_DOWN, 3'd6, 1'b0};
        vecs[14] = '{K_UP,   3'd5, 1'b0};

        // Reset state, then row sequence with no keys
        repeat (2) @(negedge clk);
        check("reset_row", 32'(keypadRow), 32'h0000000E);
        check("reset_pos", 32'(playerPos), 32'd3);
        check("reset_fire", 32'(fire), 32'd0);
        rst = 1'b1;
        for (int k = 0; k <= 46; k++) begin
            check("row_seq", 32'(keypadRow), 32'(exp_row(k)));
            @(negedge clk);
        end
        check("idle_pos", 32'(playerPos), 32'd3);
        check("idle_fire", 32'(fire), 32'd0);

        // Hold UP for 10 scans: exactly one step, within 6 scans
        keys = K_UP;
        changes = 0;
        first_chg = -1;
        last = playerPos;
        for (int c = 0; c < 10 * SCAN_CYC; c++) begin
            @(negedge clk);
            if (playerPos !== last) begin
                changes++;
                if (first_chg < 0) first_chg = c;
                last = playerPos;
            end
        end
        check("hold_up_pos", 32'(playerPos), 32'd2);
        check("hold_up_steps", 32'(changes), 32'd1);
        check("hold_up_latency_ok", 32'(first_chg >= 0 && first_chg <= 6 * SCAN_CYC), 32'd1);
        keys = '0;
        wait_scans(7);
        check("hold_up_release_pos", 32'(playerPos), 32'd2);

        // Bounce: UP toggling each scan for 3 scans must never be accepted
        keys = K_UP;  wait_scans(1);
        keys = '0;    wait_scans(1);
        keys = K_UP;  wait_scans(1);
        keys = '0;    wait_scans(8);
        check("bounce_pos", 32'(playerPos), 32'd2);

        // Table-driven presses through the scoreboard
        do_reset();
        @(negedge clk);
        check("table_start_pos", 32'(playerPos), 32'd3);
        for (int i = 0; i < 15; i++) begin
            keys = vecs[i].keys;
            sb.push_back('{vecs[i].exp_pos, vecs[i].exp_fire});
            wait_scans(7);
            e = sb.pop_front();
            check($sformatf("vec%0d_hold_pos", i), 32'(playerPos), 32'(e.pos));
            check($sformatf("vec%0d_hold_fire", i), 32'(fire), 32'(e.fire));
            keys = '0;
            sb.push_back('{vecs[i].exp_pos, 1'b0});
            wait_scans(7);
            e = sb.pop_front();
            check($sformatf("vec%0d_rel_pos", i), 32'(playerPos), 32'(e.pos));
            check($sformatf("vec%0d_rel_fire", i), 32'(fire), 32'(e.fire));
        end

        // Reset mid-row-2 with DOWN held at pos 5, then held key is a new press
        keys = K_DOWN;
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk);
            if (keypadRow == 4'b1011) found = 1'b1;
        end
        check("row2_reached", 32'(found), 32'd1);
        repeat (2) @(negedge clk);
        check("pre_reset_pos", 32'(playerPos), 32'd5);
        rst = 1'b0;
        #1;
        check("midreset_pos", 32'(playerPos), 32'd3);
        check("midreset_row", 32'(keypadRow), 32'h0000000E);
        check("midreset_fire", 32'(fire), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wait_scans(7);
        check("post_reset_pos", 32'(playerPos), 32'd4);
        keys = '0;
        wait_scans(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
